fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, prefetch entries; power of two, 2..16.
REQ-002 SHALL have parameter PC_RESET, default 32'h01000000, first fetch address.
REQ-003 SHALL have port clock  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port imem_address  output  32  byte address to instruction memory.
REQ-006 SHALL have port imem_read_write  output  1  memory direction; constant 0 (read).
REQ-007 SHALL have port imem_data_in  input  32  little-endian word returned combinationally for imem_address.
REQ-008 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-009 SHALL have port redirect_target  input  32  redirect byte address.
REQ-010 SHALL have port inst_ready  input  1  downstream accepts instruction.
REQ-011 SHALL have port inst_valid  output  1  FIFO head holds an instruction.
REQ-012 SHALL have port inst_data  output  32  instruction at FIFO head.
REQ-013 SHALL have port inst_pc  output  32  address of inst_data.
REQ-014 SHALL have port fetch_fault  output  1  misaligned-redirect fault (see Configuration).

Function
REQ-015 SHALL drive imem_address = fetch_pc combinationally; imem_read_write tied 0.
REQ-016 SHALL push {fetch_pc, imem_data_in} and advance fetch_pc by 4 in any cycle with: state RUN, no redirect_valid, and (count < FIFO_DEPTH or pop this cycle).
REQ-017 SHALL pop when inst_valid and inst_ready; inst_valid = (count != 0); head data stable while inst_valid and not inst_ready.
REQ-018 SHALL support push and pop in the same cycle at full and at empty-plus-one; count unchanged.
REQ-019 SHALL wrap fetch_pc modulo 2^32 (32'hFFFFFFFC + 4 = 0).
REQ-020 SHALL, on redirect_valid, flush all entries (count 0 next cycle), load fetch_pc with target, and push nothing that cycle; a head handshake in that cycle counts as consumed.
REQ-021 SHALL present first instruction (inst_valid=1, inst_pc=PC_RESET) one cycle after reset release; redirect-to-valid latency is 2 cycles.
REQ-022 SHALL implement states RUN and FAULT; RUN->FAULT on faulting redirect; FAULT->RUN only on aligned redirect; misaligned redirect in FAULT stays FAULT; no pushes in FAULT.

Reset
REQ-023 SHALL, while reset low, set fetch_pc=PC_RESET, count=0, pointers=0, state RUN, inst_valid=0, fetch_fault=0, inst_data=0, inst_pc=0.
REQ-024 SHALL discard all buffered entries on reset asserted mid-operation, independent of clock.

Configuration
REQ-025 SHALL use macro FETCH_MISALIGN_CHECK_EN.
REQ-026 SHALL, with macro defined, treat redirect_target[1:0] != 0 as fault: flush, fetch_fault=1 registered, enter FAULT; fetch_fault clears on leaving FAULT.
REQ-027 SHALL, without macro, force redirect_target[1:0] to 0, never enter FAULT, tie fetch_fault 0.

Structure
REQ-028 SHALL place PC_RESET default constant, fetch-entry typedef {pc[31:0], inst[31:0]}, and state enum in package fetch_pkg.
REQ-029 SHALL implement buffering in one sub-module fetch_fifo (push/pop/flush, count, full/empty).

Verification
REQ-030 SHALL cover reset release with memory word 0x00500093 at 0x01000000, inst_ready=1 -> cycle 1 inst_valid=1, inst_pc=0x01000000, inst_data=0x00500093; next inst_pc 0x01000004.
REQ-031 SHALL cover inst_ready=0 for 10 cycles, FIFO_DEPTH=4 -> exactly 4 entries, fetch_pc stalls at 0x01000010, head unchanged; release -> 4 pops in order, no gaps.
REQ-032 SHALL cover redirect to 0x01000040 with 3 entries buffered -> inst_valid=0 next cycle, next inst_pc=0x01000040.
REQ-033 SHALL cover redirect to 0x01000042 with macro -> fetch_fault=1, no valid; then redirect 0x01000048 -> fault clears, inst_pc=0x01000048; without macro -> inst_pc=0x01000040, fault 0.
REQ-034 SHALL cover redirect to 0xFFFFFFFC -> inst_pc sequence 0xFFFFFFFC, 0x00000000.
REQ-035 SHALL cover reset asserted asynchronously with full FIFO -> inst_valid drops immediately; after release inst_pc=0x01000000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Misaligned-redirect faulting is enabled by defining FETCH_MISALIGN_CHECK_EN.
package fetch_pkg;

  localparam logic [31:0] FETCH_PC_RESET = 32'h0100_0000;
  // Wide enough to hold a count of 16 entries, the largest FIFO depth.
  localparam int FETCH_CNT_W = 5;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer holding {pc, inst} entries, with a single-cycle flush.
// The head reads as zero whenever the buffer is empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           push_entry,
  output fetch_entry_t           head_entry,
  output logic [FETCH_CNT_W-1:0] count,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [FETCH_CNT_W-1:0] DEPTH_CNT = FETCH_CNT_W'(DEPTH);

  fetch_entry_t           mem [DEPTH];
  logic [AW-1:0]          wr_ptr_reg;
  logic [AW-1:0]          rd_ptr_reg;
  logic [FETCH_CNT_W-1:0] count_reg;
  logic                   full;
  logic                   push_ok;
  logic                   pop_ok;

  assign empty      = (count_reg == '0);
  assign full       = (count_reg == DEPTH_CNT);
  assign pop_ok     = pop && !empty;
  // A pop in the same cycle frees a slot, so a full buffer may still accept.
  assign push_ok    = push && (!full || pop_ok);
  assign count      = count_reg;
  assign head_entry = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push_ok && !pop_ok)
        count_reg <= count_reg + 1'b1;
      else if (pop_ok && !push_ok)
        count_reg <= count_reg - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok && !flush) mem[wr_ptr_reg] <= push_entry;
  end

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction prefetcher with branch redirect and buffered output.
// Define FETCH_MISALIGN_CHECK_EN to fault on redirects to non-word-aligned targets.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] PC_RESET   = FETCH_PC_RESET
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imem_address,
  output logic        imem_read_write,
  input  logic [31:0] imem_data_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        inst_ready,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        fetch_fault
);

  localparam logic [FETCH_CNT_W-1:0] DEPTH_CNT = FETCH_CNT_W'(FIFO_DEPTH);

  logic [31:0]            fetch_pc_reg;
  fetch_state_t           state_reg;
  logic                   push;
  logic                   pop;
  logic                   fifo_empty;
  logic [FETCH_CNT_W-1:0] fifo_count;
  fetch_entry_t           head_entry;

  assign imem_address    = fetch_pc_reg;
  assign imem_read_write = 1'b0;
  assign inst_valid      = !fifo_empty;
  assign inst_pc         = head_entry.pc;
  assign inst_data       = head_entry.inst;
  assign pop             = inst_valid && inst_ready;
  assign push            = (state_reg == ST_RUN) && !redirect_valid &&
                           ((fifo_count < DEPTH_CNT) || pop);

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_reg;
  assign fetch_fault = fault_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_reg <= PC_RESET;
      state_reg    <= ST_RUN;
      fault_reg    <= 1'b0;
    end else if (redirect_valid) begin
      // A misaligned target leaves fetch_pc alone; only an aligned redirect restarts fetch.
      if (redirect_target[1:0] != 2'b00) begin
        state_reg <= ST_FAULT;
        fault_reg <= 1'b1;
      end else begin
        state_reg    <= ST_RUN;
        fault_reg    <= 1'b0;
        fetch_pc_reg <= redirect_target;
      end
    end else if (push) begin
      fetch_pc_reg <= fetch_pc_reg + 32'd4;
    end
  end
`else
  assign fetch_fault = 1'b0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_reg <= PC_RESET;
      state_reg    <= ST_RUN;
    end else if (redirect_valid) begin
      fetch_pc_reg <= redirect_target & 32'hFFFF_FFFC;
    end else if (push) begin
      fetch_pc_reg <= fetch_pc_reg + 32'd4;
    end
  end
`endif

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_valid),
    .push_entry('{pc: fetch_pc_reg, inst: imem_data_in}),
    .head_entry(head_entry),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table plus randomized run
// against a queue-based reference model.
module tb_fetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] PCR   = 32'h0100_0000;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic [31:0] imem_address;
  logic        imem_read_write;
  logic [31:0] imem_data_in;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        inst_ready;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        fetch_fault;

  int tests = 0;
  int fails = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == PCR) return 32'h0050_0093;
    return {a[15:0], ~a[31:16]} ^ 32'h0000_0013;
  endfunction

  assign imem_data_in = mem_word(imem_address);

  fetch_unit #(.FIFO_DEPTH(DEPTH), .PC_RESET(PCR)) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_address   (imem_address),
    .imem_read_write(imem_read_write),
    .imem_data_in   (imem_data_in),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .inst_ready     (inst_ready),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .fetch_fault    (fetch_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: buffered pcs in fetch order, next fetch address, fault flag.
  logic [31:0] m_q[$];
  logic [31:0] m_pc;
  bit          m_fault;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc    = PCR;
    m_fault = 1'b0;
  endtask

  task automatic model_edge(input bit rv, input logic [31:0] tgt, input bit rdy);
    if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
    if (rv) begin
      m_q.delete();
      if (MIS && (tgt % 4 != 0)) begin
        m_fault = 1'b1;
      end else begin
        m_fault = 1'b0;
        m_pc    = tgt - (tgt % 4);
      end
    end else if (!m_fault && m_q.size() < DEPTH) begin
      m_q.push_back(m_pc);
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic check_model();
    chk("valid", 32'(inst_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("pc", inst_pc, m_q[0]);
      chk("data", inst_data, mem_word(m_q[0]));
    end
    chk("fault", 32'(fetch_fault), 32'(m_fault));
    chk("imem_addr", imem_address, m_pc);
    chk("imem_rw", 32'(imem_read_write), 32'd0);
    $display("[TB] cyc rv=%0b tgt=%08h rdy=%0b -> valid=%0b pc=%08h data=%08h fault=%0b addr=%08h",
             redirect_valid, redirect_target, inst_ready, inst_valid, inst_pc, inst_data,
             fetch_fault, imem_address);
  endtask

  task automatic cycle(input bit rv, input logic [31:0] tgt, input bit rdy);
    redirect_valid  = rv;
    redirect_target = tgt;
    inst_ready      = rdy;
    @(posedge clock);
    model_edge(rv, tgt, rdy);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset          = 1'b0;
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    #1;
    model_reset();
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_pc", inst_pc, 32'd0);
    chk("rst_data", inst_data, 32'd0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    chk("rst_addr", imem_address, PCR);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic async_reset_mid();
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_valid", 32'(inst_valid), 32'd0);
    chk("async_rst_pc", inst_pc, 32'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  typedef struct {
    bit          rst;
    bit          rv;
    logic [31:0] tgt;
    bit          rdy;
    bit          ev;
    logic [31:0] epc;
    bit          ef;
  } row_t;

  row_t tbl[$];

  task automatic add(input bit rst, input bit rv, input logic [31:0] tgt, input bit rdy,
                     input bit ev, input logic [31:0] epc, input bit ef);
    row_t r;
    r.rst = rst; r.rv = rv; r.tgt = tgt; r.rdy = rdy;
    r.ev = ev; r.epc = epc; r.ef = ef;
    tbl.push_back(r);
  endtask

  initial begin
    reset           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    inst_ready      = 1'b1;
    model_reset();

    // Reset release with ready held high.
    add(1, 0, 0, 1, 1, PCR, 0);
    add(0, 0, 0, 1, 1, PCR + 32'd4, 0);
    // Stall for ten cycles: buffer fills to four, head holds, then drains in order.
    add(1, 0, 0, 0, 1, PCR, 0);
    for (int k = 0; k < 9; k++) add(0, 0, 0, 0, 1, PCR, 0);
    for (int k = 1; k <= 4; k++) add(0, 0, 0, 1, 1, PCR + 32'(4 * k), 0);
    // Redirect with three buffered, misaligned redirect, recovery, address wrap.
    add(1, 0, 0, 0, 1, PCR, 0);
    add(0, 0, 0, 0, 1, PCR, 0);
    add(0, 0, 0, 0, 1, PCR, 0);
    add(0, 1, 32'h0100_0040, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 32'h0100_0040, 0);
    add(0, 1, 32'h0100_0042, 1, 0, 0, MIS);
    add(0, 0, 0, 1, !MIS, 32'h0100_0040, MIS);
    add(0, 0, 0, 1, !MIS, 32'h0100_0044, MIS);
    add(0, 1, 32'h0100_0048, 1, 0, 0, 0);
    add(0, 0, 0, 1, 1, 32'h0100_0048, 0);
    add(0, 1, 32'hFFFF_FFFC, 1, 0, 0, 0);
    add(0, 0, 0, 1, 1, 32'hFFFF_FFFC, 0);
    add(0, 0, 0, 1, 1, 32'h0000_0000, 0);
    add(0, 0, 0, 1, 1, 32'h0000_0004, 0);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      cycle(tbl[i].rv, tbl[i].tgt, tbl[i].rdy);
      chk($sformatf("row%0d_valid", i), 32'(inst_valid), 32'(tbl[i].ev));
      chk($sformatf("row%0d_fault", i), 32'(fetch_fault), 32'(tbl[i].ef));
      if (tbl[i].ev) begin
        chk($sformatf("row%0d_pc", i), inst_pc, tbl[i].epc);
        if (tbl[i].epc == PCR)
          chk($sformatf("row%0d_first_word", i), inst_data, 32'h0050_0093);
      end
    end

    // Asynchronous reset while the buffer is full.
    do_reset();
    for (int k = 0; k < 6; k++) cycle(0, 0, 0);
    chk("full_before_rst", 32'(inst_valid), 32'd1);
    async_reset_mid();
    cycle(0, 0, 1);
    chk("after_async_pc", inst_pc, PCR);
    chk("after_async_valid", 32'(inst_valid), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] tgt;
      bit          rv;
      bit          rdy;
      if (i % 500 == 250) async_reset_mid();
      rv  = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else tgt = $urandom;
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      cycle(rv, tgt, rdy);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
